control_unit: RTL and testbench

- Processor control unit: fetch/decode/execute FSM owning the program counter (PC) and instruction register (IR).
- Drives instruction-ROM address, data-memory and register-file controls, and ALU select for the datapath.
- Exports PC, IR and state code to the board top level, which shows them on the hex displays.
- Instruction ROM is asynchronous-read. Data memory is synchronous-read, with one cycle of latency.

---
 rtl/ctrl_pkg.sv | 37 +++
 rtl/control_unit_program_counter.sv | 38 +++
 rtl/control_unit.sv | 149 ++++++++++++++
 tb/tb_control_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared constants for the processor control unit and its datapath:
// opcode values, the 4-bit state encoding shown on the hex displays,
// and the ALU function selects.
package ctrl_pkg;

   localparam logic [3:0] OP_NOOP  = 4'd0;
   localparam logic [3:0] OP_STORE = 4'd1;
   localparam logic [3:0] OP_LOAD  = 4'd2;
   localparam logic [3:0] OP_ADD   = 4'd3;
   localparam logic [3:0] OP_SUB   = 4'd4;
   localparam logic [3:0] OP_HALT  = 4'd5;
   localparam logic [3:0] OP_JMP   = 4'd6;

   localparam logic [2:0] ALU_PASS = 3'd0;
   localparam logic [2:0] ALU_ADD  = 3'd1;
   localparam logic [2:0] ALU_SUB  = 3'd2;

   // The encoding doubles as the display code, so the values are fixed.
   typedef enum logic [3:0] {
      ST_INIT   = 4'd0,
      ST_FETCH  = 4'd1,
      ST_DECODE = 4'd2,
      ST_NOOP   = 4'd3,
      ST_LOADA  = 4'd4,
      ST_LOADB  = 4'd5,
      ST_STORE  = 4'd6,
      ST_ADD    = 4'd7,
      ST_SUB    = 4'd8,
      ST_HALT   = 4'd9,
      ST_JUMP   = 4'd10
   } state_e;

   function automatic logic [3:0] opcodeOf(input logic [15:0] ir);
      return ir[15:12];
   endfunction

endpackage

// File: rtl/control_unit_program_counter.sv
// Program counter register: async clear, increment, and a jump load that
// takes priority over increment. Increment wraps silently at 2^PC_W.
module program_counter #(
   parameter int PC_W = 5
) (
   input  logic            Clk,
   input  logic            Reset,
   input  logic            inc_i,
   input  logic            load_i,
   input  logic [PC_W-1:0] target_i,
   output logic [PC_W-1:0] pc_o
);

   logic [PC_W-1:0] pc_q;
   logic [PC_W-1:0] pc_d;

   // Choose the next PC; a jump load wins over a pending increment.
   always_comb begin
      pc_d = pc_q;
      if (load_i) begin
         pc_d = target_i;
      end else if (inc_i) begin
         pc_d = pc_q + PC_W'(1);
      end
   end

   // PC register, cleared immediately by Reset.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         pc_q <= '0;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/control_unit.sv
// Fetch/decode/execute control unit owning the PC and instruction register.
// All datapath controls are decoded combinationally from the state register
// and IR, so asserting Reset drops every write enable at once.
// Optional feature macro: CTRL_JUMP_EN adds op 6 = JMP to IR[PC_W-1:0].
module control_unit
   import ctrl_pkg::*;
#(
   parameter int PC_W = 5,
   parameter int D_AW = 8
) (
   input  logic            Clk,
   input  logic            Reset,
   input  logic [15:0]     IR_Data,
   output logic [PC_W-1:0] PC_Out,
   output logic [15:0]     IR_Out,
   output logic [3:0]      StateO,
   output logic [D_AW-1:0] D_Addr,
   output logic            D_Wr,
   output logic            RF_s,
   output logic [3:0]      RF_W_Addr,
   output logic            RF_W_En,
   output logic [3:0]      RF_Ra_Addr,
   output logic [3:0]      RF_Rb_Addr,
   output logic [2:0]      ALU_s0,
   output logic            Halted
);

   state_e      state_q;
   state_e      state_d;
   logic [15:0] ir_q;
   logic [15:0] ir_d;
   logic        pcInc;
   logic        pcLoad;

   program_counter #(.PC_W(PC_W)) u_pc (
      .Clk      (Clk),
      .Reset    (Reset),
      .inc_i    (pcInc),
      .load_i   (pcLoad),
      .target_i (ir_q[PC_W-1:0]),
      .pc_o     (PC_Out)
   );

   // Next-state logic plus the IR capture and PC step taken in Fetch/Jump.
   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      pcInc   = 1'b0;
      pcLoad  = 1'b0;
      case (state_q)
         ST_INIT: begin
            state_d = ST_FETCH;
         end
         ST_FETCH: begin
            ir_d    = IR_Data;
            pcInc   = 1'b1;
            state_d = ST_DECODE;
         end
         ST_DECODE: begin
            case (opcodeOf(ir_q))
               OP_STORE: state_d = ST_STORE;
               OP_LOAD:  state_d = ST_LOADA;
               OP_ADD:   state_d = ST_ADD;
               OP_SUB:   state_d = ST_SUB;
               OP_HALT:  state_d = ST_HALT;
`ifdef CTRL_JUMP_EN
               OP_JMP:   state_d = ST_JUMP;
`endif
               default:  state_d = ST_NOOP;
            endcase
         end
         ST_LOADA: begin
            state_d = ST_LOADB;
         end
         ST_LOADB, ST_NOOP, ST_STORE, ST_ADD, ST_SUB: begin
            state_d = ST_FETCH;
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         ST_JUMP: begin
`ifdef CTRL_JUMP_EN
            pcLoad  = 1'b1;
`endif
            state_d = ST_FETCH;
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase
   end

   // State and instruction registers, both cleared by Reset.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= ST_INIT;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
      end
   end

   // Datapath controls decoded from the current state and IR fields.
   always_comb begin
      D_Addr     = '0;
      D_Wr       = 1'b0;
      RF_s       = 1'b0;
      RF_W_Addr  = 4'd0;
      RF_W_En    = 1'b0;
      RF_Ra_Addr = 4'd0;
      RF_Rb_Addr = 4'd0;
      ALU_s0     = ALU_PASS;
      Halted     = 1'b0;
      case (state_q)
         ST_LOADA: begin
            D_Addr    = ir_q[4 +: D_AW];
            RF_W_Addr = ir_q[3:0];
         end
         ST_LOADB: begin
            D_Addr    = ir_q[4 +: D_AW];
            RF_s      = 1'b1;
            RF_W_Addr = ir_q[3:0];
            RF_W_En   = 1'b1;
         end
         ST_STORE: begin
            D_Addr     = ir_q[4 +: D_AW];
            RF_Ra_Addr = ir_q[3:0];
            D_Wr       = 1'b1;
         end
         ST_ADD, ST_SUB: begin
            RF_Ra_Addr = ir_q[11:8];
            RF_Rb_Addr = ir_q[7:4];
            ALU_s0     = (state_q == ST_ADD) ? ALU_ADD : ALU_SUB;
            RF_W_Addr  = ir_q[3:0];
            RF_W_En    = 1'b1;
         end
         ST_HALT: begin
            Halted = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign IR_Out = ir_q;
   assign StateO = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit. A cycle-level reference schedule is
// expanded from the instruction set (instruction -> list of steps) and every
// cycle's state, PC, IR and control outputs are compared against it.
module tb_control_unit;

   localparam int PC_W = 5;
   localparam int D_AW = 8;
   localparam int ROM_DEPTH = 32;
`ifdef CTRL_JUMP_EN
   localparam bit JUMP_EN = 1'b1;
`else
   localparam bit JUMP_EN = 1'b0;
`endif

   logic            Clk = 1'b0;
   logic            Reset = 1'b1;
   logic [15:0]     IR_Data;
   logic [PC_W-1:0] PC_Out;
   logic [15:0]     IR_Out;
   logic [3:0]      StateO;
   logic [D_AW-1:0] D_Addr;
   logic            D_Wr;
   logic            RF_s;
   logic [3:0]      RF_W_Addr;
   logic            RF_W_En;
   logic [3:0]      RF_Ra_Addr;
   logic [3:0]      RF_Rb_Addr;
   logic [2:0]      ALU_s0;
   logic            Halted;

   logic [15:0] rom [ROM_DEPTH];

   typedef struct {
      int          state;
      int          pc;
      logic [15:0] ir;
   } step_t;

   step_t plan[$];
   int    errors = 0;
   int    checks = 0;

   control_unit #(.PC_W(PC_W), .D_AW(D_AW)) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .IR_Data    (IR_Data),
      .PC_Out     (PC_Out),
      .IR_Out     (IR_Out),
      .StateO     (StateO),
      .D_Addr     (D_Addr),
      .D_Wr       (D_Wr),
      .RF_s       (RF_s),
      .RF_W_Addr  (RF_W_Addr),
      .RF_W_En    (RF_W_En),
      .RF_Ra_Addr (RF_Ra_Addr),
      .RF_Rb_Addr (RF_Rb_Addr),
      .ALU_s0     (ALU_s0),
      .Halted     (Halted)
   );

   // Asynchronous instruction ROM.
   assign IR_Data = rom[PC_Out];

   always #5 Clk = ~Clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, wanted %0h", tag, observed, expected);
      end
   endtask

   // Packs the DUT control outputs into one word for comparison.
   function automatic logic [31:0] observedCtrl();
      return {5'd0, Halted, ALU_s0, RF_Rb_Addr, RF_Ra_Addr, RF_W_En, RF_W_Addr, RF_s, D_Wr, D_Addr};
   endfunction

   // What each execution step is supposed to drive, from the instruction fields.
   function automatic logic [31:0] expectedCtrl(input int st, input logic [15:0] ir);
      logic       halt = 1'b0;
      logic [2:0] alu = 3'd0;
      logic [3:0] rb = 4'd0, ra = 4'd0, wa = 4'd0;
      logic       we = 1'b0, rfs = 1'b0, dwr = 1'b0;
      logic [7:0] da = 8'd0;
      case (st)
         4: begin da = ir[11:4]; wa = ir[3:0]; end
         5: begin da = ir[11:4]; wa = ir[3:0]; rfs = 1'b1; we = 1'b1; end
         6: begin da = ir[11:4]; ra = ir[3:0]; dwr = 1'b1; end
         7, 8: begin
            ra = ir[11:8]; rb = ir[7:4]; wa = ir[3:0]; we = 1'b1;
            alu = (st == 7) ? 3'd1 : 3'd2;
         end
         9: halt = 1'b1;
         default: ;
      endcase
      return {5'd0, halt, alu, rb, ra, we, wa, rfs, dwr, da};
   endfunction

   // Expands the ROM program into the expected cycle-by-cycle schedule.
   task automatic buildPlan(input int n);
      int          pc = 0;
      logic [15:0] ir = 16'h0000;
      int          op;
      plan.delete();
      plan.push_back('{0, 0, 16'h0000});
      while (plan.size() < n) begin
         plan.push_back('{1, pc, ir});
         ir = rom[pc];
         pc = (pc + 1) % ROM_DEPTH;
         op = int'(ir[15:12]);
         plan.push_back('{2, pc, ir});
         case (op)
            1: plan.push_back('{6, pc, ir});
            2: begin
               plan.push_back('{4, pc, ir});
               plan.push_back('{5, pc, ir});
            end
            3: plan.push_back('{7, pc, ir});
            4: plan.push_back('{8, pc, ir});
            5: while (plan.size() < n) plan.push_back('{9, pc, ir});
            6: begin
               if (JUMP_EN) begin
                  plan.push_back('{10, pc, ir});
                  pc = int'(ir[PC_W-1:0]);
               end else begin
                  plan.push_back('{3, pc, ir});
               end
            end
            default: plan.push_back('{3, pc, ir});
         endcase
      end
   endtask

   // Resets the DUT, checks the reset values, then runs n cycles against the plan.
   task automatic applyStimulus(input string name, input int n);
      buildPlan(n);
      @(negedge Clk);
      Reset = 1'b1;
      #1;
      checkOutput({name, ":resetState"}, 32'(StateO), 32'd0);
      checkOutput({name, ":resetCtrl"}, observedCtrl(), 32'd0);
      @(negedge Clk);
      checkOutput({name, ":resetPc"}, 32'(PC_Out), 32'd0);
      checkOutput({name, ":resetIr"}, 32'(IR_Out), 32'd0);
      Reset = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (i > 0) @(negedge Clk);
         #1;
         checkOutput($sformatf("%s:state@%0d", name, i), 32'(StateO), 32'(plan[i].state));
         checkOutput($sformatf("%s:pc@%0d", name, i), 32'(PC_Out), 32'(plan[i].pc));
         checkOutput($sformatf("%s:ir@%0d", name, i), 32'(IR_Out), 32'(plan[i].ir));
         checkOutput($sformatf("%s:ctrl@%0d", name, i), observedCtrl(), expectedCtrl(plan[i].state, plan[i].ir));
      end
   endtask

   task automatic clearRom();
      for (int i = 0; i < ROM_DEPTH; i++) rom[i] = 16'h0000;
   endtask

   initial begin
      clearRom();

      // All-NOOP program long enough for the PC to wrap past 31.
      applyStimulus("noopWrap", 1 + 33 * 3);

      // Single LOAD, then reset while it sits in LoadB.
      clearRom();
      rom[0] = 16'h21B3;
      applyStimulus("load", 5);
      checkOutput("loadB:wen", 32'(RF_W_En), 32'd1);
      Reset = 1'b1;
      #1;
      checkOutput("midReset:wen", 32'(RF_W_En), 32'd0);
      checkOutput("midReset:state", 32'(StateO), 32'd0);
      checkOutput("midReset:ctrl", observedCtrl(), 32'd0);
      applyStimulus("loadRun", 12);

      // ADD followed by SUB.
      clearRom();
      rom[0] = 16'h3125;
      rom[1] = 16'h4125;
      applyStimulus("addSub", 10);

      // STORE.
      clearRom();
      rom[0] = 16'h1A27;
      applyStimulus("store", 10);

      // HALT at address 2 must hold indefinitely.
      clearRom();
      rom[2] = 16'h5000;
      applyStimulus("halt", 30);
      checkOutput("halt:pcHeld", 32'(PC_Out), 32'd3);
      checkOutput("halt:halted", 32'(Halted), 32'd1);

      // Jump (or NOOP without the feature) to address 4.
      clearRom();
      rom[0] = 16'h6004;
      rom[4] = 16'h3125;
      rom[1] = 16'h4125;
      applyStimulus("jump", 12);

      // Random programs.
      for (int p = 0; p < 6; p++) begin
         for (int i = 0; i < ROM_DEPTH; i++) rom[i] = 16'($urandom);
         applyStimulus($sformatf("rand%0d", p), 80);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
